// File: rtl/alu_share_arb_pkg.sv
// Shared types, ALU function codes and legality check for the shared-ALU arbiter.
// The optional illegal-func check (ALU_SHARE_ARB_ILLEGAL_CHK_EN) uses is_legal_func.
package alu_share_arb_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned FUNC_W         = 5;
    localparam int unsigned CODE_W         = 4;
    localparam int unsigned FUNC_CLASS_BIT = 4;

    // Arithmetic/logic codes (func[4] = 0)
    localparam logic [CODE_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CODE_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [CODE_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [CODE_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [CODE_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [CODE_W-1:0] ALU_MVHI = 4'b1011;
    localparam logic [CODE_W-1:0] ALU_NAND = 4'b1100;
    localparam logic [CODE_W-1:0] ALU_NOR  = 4'b1101;
    localparam logic [CODE_W-1:0] ALU_NXOR = 4'b1110;

    // Compare codes (func[4] = 1); bit3 inverts, bit2 compares against zero
    localparam logic [CODE_W-1:0] CMP_F    = 4'b0000;
    localparam logic [CODE_W-1:0] CMP_EQ   = 4'b0001;
    localparam logic [CODE_W-1:0] CMP_LT   = 4'b0010;
    localparam logic [CODE_W-1:0] CMP_LE   = 4'b0011;
    localparam logic [CODE_W-1:0] CMP_EQZ  = 4'b0101;
    localparam logic [CODE_W-1:0] CMP_LTZ  = 4'b0110;
    localparam logic [CODE_W-1:0] CMP_LEZ  = 4'b0111;
    localparam logic [CODE_W-1:0] CMP_T    = 4'b1000;
    localparam logic [CODE_W-1:0] CMP_NE   = 4'b1001;
    localparam logic [CODE_W-1:0] CMP_GE   = 4'b1010;
    localparam logic [CODE_W-1:0] CMP_GT   = 4'b1011;
    localparam logic [CODE_W-1:0] CMP_NEZ  = 4'b1101;
    localparam logic [CODE_W-1:0] CMP_GEZ  = 4'b1110;
    localparam logic [CODE_W-1:0] CMP_GTZ  = 4'b1111;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_op_t;

    function automatic logic is_legal_func(input logic [FUNC_W-1:0] func);
        logic legal;
        legal = 1'b0;
        if (func[FUNC_CLASS_BIT]) begin
            legal = (func[2:0] != 3'b100);
        end else begin
            case (func[CODE_W-1:0])
                ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                ALU_MVHI, ALU_NAND, ALU_NOR, ALU_NXOR: legal = 1'b1;
                default:                               legal = 1'b0;
            endcase
        end
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first valid request at or after ptr_i when enabled.
module alu_share_arb_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_vld_o
);

    int unsigned cand;

    // Scan from the pointer, wrapping modulo NREQ; ptr_i < NREQ so one subtract suffices
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (en_i && !gnt_vld_o && req_i[IDW'(cand)]) begin
                gnt_vld_o               = 1'b1;
                gnt_idx_o               = IDW'(cand);
                gnt_oh_o[IDW'(cand)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational 32-bit ALU among NREQ requesters with a single registered result slot.
// Optional macro ALU_SHARE_ARB_ILLEGAL_CHK_EN flags illegal funcs via rsp_err_o.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*32-1:0]   req_a_i,
    input  logic [NREQ*32-1:0]   req_b_i,
    input  logic [NREQ*5-1:0]    req_func_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_W-1:0]    rsp_data_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic                 rsp_err_o
);

    slot_state_e        state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               err_q, err_d;
    logic [IDW-1:0]     rr_q, rr_d;

    logic               can_issue_c;
    logic [NREQ-1:0]    gnt_oh;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_vld;

    alu_op_t            op_arr [NREQ];
    alu_op_t            sel_op;
    logic [DATA_W-1:0]  alu_res;
    logic               cmp_bit;
    logic               eq, lt, eqz, ltz;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_arr[i] = '{func: req_func_i[FUNC_W*i +: FUNC_W],
                             a:    req_a_i[DATA_W*i +: DATA_W],
                             b:    req_b_i[DATA_W*i +: DATA_W]};
    end

    // Gated by rst_n so nothing looks accepted while reset is asserted
    assign can_issue_c = rst_n && ((state_q == SLOT_EMPTY) || rsp_ready_i);

    alu_share_arb_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (rr_q),
        .en_i      (can_issue_c),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready_o = gnt_oh;
    assign sel_op      = op_arr[gnt_idx];

    // Shared ALU: 32-bit wrap arithmetic, signed compares yielding 0/1
    always_comb begin
        eq      = (sel_op.a == sel_op.b);
        lt      = ($signed(sel_op.a) < $signed(sel_op.b));
        eqz     = (sel_op.a == '0);
        ltz     = sel_op.a[DATA_W-1];
        cmp_bit = 1'b0;
        alu_res = '0;
        if (sel_op.func[FUNC_CLASS_BIT]) begin
            case (sel_op.func[CODE_W-1:0])
                CMP_F:   cmp_bit = 1'b0;
                CMP_EQ:  cmp_bit = eq;
                CMP_LT:  cmp_bit = lt;
                CMP_LE:  cmp_bit = lt | eq;
                CMP_EQZ: cmp_bit = eqz;
                CMP_LTZ: cmp_bit = ltz;
                CMP_LEZ: cmp_bit = ltz | eqz;
                CMP_T:   cmp_bit = 1'b1;
                CMP_NE:  cmp_bit = !eq;
                CMP_GE:  cmp_bit = !lt;
                CMP_GT:  cmp_bit = !(lt | eq);
                CMP_NEZ: cmp_bit = !eqz;
                CMP_GEZ: cmp_bit = !ltz;
                CMP_GTZ: cmp_bit = !(ltz | eqz);
                default: cmp_bit = 1'bx;
            endcase
            alu_res = {{(DATA_W-1){1'b0}}, cmp_bit};
        end else begin
            case (sel_op.func[CODE_W-1:0])
                ALU_ADD:  alu_res = sel_op.a + sel_op.b;
                ALU_SUB:  alu_res = sel_op.a - sel_op.b;
                ALU_AND:  alu_res = sel_op.a & sel_op.b;
                ALU_OR:   alu_res = sel_op.a | sel_op.b;
                ALU_XOR:  alu_res = sel_op.a ^ sel_op.b;
                ALU_MVHI: alu_res = {sel_op.b[15:0], 16'h0000};
                ALU_NAND: alu_res = ~(sel_op.a & sel_op.b);
                ALU_NOR:  alu_res = ~(sel_op.a | sel_op.b);
                ALU_NXOR: alu_res = ~(sel_op.a ^ sel_op.b);
                default:  alu_res = 'x;
            endcase
        end
    end

    // Slot FSM next state and result/pointer loads
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        rr_d    = rr_q;
        if (gnt_vld) begin
            state_d = SLOT_FULL;
            id_d    = gnt_idx;
`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
            if (is_legal_func(sel_op.func)) begin
                data_d = alu_res;
                err_d  = 1'b0;
            end else begin
                data_d = '0;
                err_d  = 1'b1;
            end
`else
            data_d  = alu_res;
            err_d   = 1'b0;
`endif
            rr_d    = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        end else if ((state_q == SLOT_FULL) && rsp_ready_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
        end
    end

    assign rsp_valid_o = (state_q == SLOT_FULL);
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with NREQ=2.
module tb_alu_share_arb;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*5-1:0] req_func;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] va   [12];
    logic [31:0] vb   [12];
    logic [4:0]  vf   [12];
    logic [31:0] vexp [12];

    alu_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_func_i  (req_func),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .rsp_err_o   (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [4:0] f);
        req_a[idx*32 +: 32]  = a;
        req_b[idx*32 +: 32]  = b;
        req_func[idx*5 +: 5] = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_op(0, 32'd1, 32'd2, 5'b00000);
        set_op(1, 32'd3, 32'd4, 5'b00000);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%h exp=0", rsp_id); end
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_req_ready got=%b exp=00", req_ready); end
    endtask

    // rr_ptr starts at 0: grants 0,1,0,1 with one result per cycle
    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_data;
        set_op(0, 32'd1, 32'd2, 5'b00000);
        set_op(1, 32'd10, 32'd3, 5'b00001);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            req_valid = (k < 4) ? 2'b11 : 2'b00;
            rsp_ready = 1'b1;
            #1;
            if (k < 4) begin
                exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
                n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
            end
            if (k > 0) begin
                exp_data = ((k - 1) % 2 == 0) ? 32'd3 : 32'd7;
                n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid k=%0d got=%b exp=1", k, rsp_valid); end
                n_tests++; if (rsp_id !== 1'((k - 1) % 2)) begin n_fail++; $display("FAIL rr_id k=%0d got=%0d exp=%0d", k, rsp_id, (k - 1) % 2); end
                n_tests++; if (rsp_data !== exp_data) begin n_fail++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, rsp_data, exp_data); end
            end
        end
        @(negedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_single_op();
        @(negedge clk);
        set_op(0, 32'd7, 32'hFFFF_FFFD, 5'b00001);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
        n_tests++; if (rsp_data !== 32'd10) begin n_fail++; $display("FAIL single_data got=%h exp=%h", rsp_data, 32'd10); end
        n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
        n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b exp=0", rsp_err); end
        @(negedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        set_op(0, 32'hFFFF_FFFB, 32'd0, 5'b10110);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=01", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_op(1, 32'd5, 32'd6, 5'b00000);
            req_valid = 2'b10;
            rsp_ready = 1'b0;
            #1;
            n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, rsp_valid); end
            n_tests++; if (rsp_data !== 32'd1) begin n_fail++; $display("FAIL bp_hold_data i=%0d got=%h exp=1", i, rsp_data); end
            n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold_id i=%0d got=%0d exp=0", i, rsp_id); end
            n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_stall_ready i=%0d got=%b exp=00", i, req_ready); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=10", req_ready); end
        n_tests++; if (rsp_data !== 32'd1) begin n_fail++; $display("FAIL bp_release_data got=%h exp=1", rsp_data); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got=%b exp=1", rsp_valid); end
        n_tests++; if (rsp_data !== 32'd11) begin n_fail++; $display("FAIL bp_next_data got=%h exp=%h", rsp_data, 32'd11); end
        n_tests++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL bp_next_id got=%0d exp=1", rsp_id); end
        @(negedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", rsp_valid); end
    endtask

    // Back-to-back ops from requester 0 covering wrap, MVHI, logic and compares
    task automatic test_alu_ops();
        va   = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h8000_0000,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd4, 32'd0, 32'hF0F0_F0F0};
        vb   = '{32'd1, 32'h0000_ABCD, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'd1,
                 32'd1, 32'd1, 32'd5, 32'd9, 32'd0, 32'hFF00_FF00};
        vf   = '{5'b00000, 5'b01011, 5'b00100, 5'b00110, 5'b01100, 5'b00001,
                 5'b10010, 5'b11011, 5'b10001, 5'b11111, 5'b11000, 5'b01101};
        vexp = '{32'h8000_0000, 32'hABCD_0000, 32'hF000_F000, 32'h0FF0_0FF0, 32'h0FFF_0FFF, 32'h7FFF_FFFF,
                 32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'h000F_000F};
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k < 12) begin
                set_op(0, va[k], vb[k], vf[k]);
                req_valid = 2'b01;
            end else begin
                req_valid = 2'b00;
            end
            rsp_ready = 1'b1;
            #1;
            if (k < 12) begin
                n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL alu_ready k=%0d got=%b exp=01", k, req_ready); end
            end
            if (k > 0) begin
                n_tests++; if (rsp_data !== vexp[k-1]) begin n_fail++; $display("FAIL alu_data k=%0d got=%h exp=%h", k - 1, rsp_data, vexp[k-1]); end
                n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL alu_err k=%0d got=%b exp=0", k - 1, rsp_err); end
            end
        end
        @(negedge clk);
    endtask

`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
    task automatic test_illegal();
        logic [4:0]  f   [3];
        logic [31:0] ea  [3];
        logic [31:0] exd [3];
        logic        exe [3];
        f   = '{5'b00010, 5'b11100, 5'b11111};
        ea  = '{32'd1, 32'd1, 32'd4};
        exd = '{32'd0, 32'd0, 32'd1};
        exe = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                set_op(0, ea[k], 32'd2, f[k]);
                req_valid = 2'b01;
            end else begin
                req_valid = 2'b00;
            end
            rsp_ready = 1'b1;
            #1;
            if (k > 0) begin
                n_tests++; if (rsp_err !== exe[k-1]) begin n_fail++; $display("FAIL illegal_err k=%0d got=%b exp=%b", k - 1, rsp_err, exe[k-1]); end
                n_tests++; if (rsp_data !== exd[k-1]) begin n_fail++; $display("FAIL illegal_data k=%0d got=%h exp=%h", k - 1, rsp_data, exd[k-1]); end
            end
        end
        @(negedge clk);
    endtask
`endif

    // rr_ptr is 1 before the reset; afterwards requester 0 must win again
    task automatic test_reset_mid();
        @(negedge clk);
        set_op(0, 32'd2, 32'd3, 5'b00000);
        set_op(1, 32'd20, 32'd30, 5'b00000);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #1;
        n_tests++; if (rsp_data !== 32'd5) begin n_fail++; $display("FAIL mid_pre_data got=%h exp=5", rsp_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL mid_async_data got=%h exp=0", rsp_data); end
        rsp_ready = 1'b1;
        #1;
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=00", req_ready); end
        @(negedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_held_valid got=%b exp=0", rsp_valid); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_ptr_reset got=%b exp=01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL mid_after_id got=%0d exp=0", rsp_id); end
        n_tests++; if (rsp_data !== 32'd5) begin n_fail++; $display("FAIL mid_after_data got=%h exp=5", rsp_data); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_func  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single_op();
        test_back_pressure();
        test_alu_ops();
`ifdef ALU_SHARE_ARB_ILLEGAL_CHK_EN
        test_illegal();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single 32-bit ALU between NREQ requesters (fetch/branch-compare unit, execute, debug port).
- Per-requester valid/ready request ports; round-robin grant.
- ALU result registered into one output slot, tagged with the requester index; single-source valid/ready response.
- Sits between the decode/issue logic and the ALU instance in the datapath.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, width of requester index; must equal clog2(NREQ), minimum 1

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  request valid, one bit per requester
req_ready  output  NREQ  request accepted this cycle (one-hot or zero)
req_a  input  NREQ*32  operand A per requester, requester i at [32*i+31:32*i], signed
req_b  input  NREQ*32  operand B per requester, same packing, signed
req_func  input  NREQ*5  ALU function per requester, requester i at [5*i+4:5*i]; bit4=1 compare, 0 arithmetic/logic
rsp_valid  output  1  result slot full
rsp_ready  input  1  consumer takes result this cycle
rsp_data  output  32  registered ALU result
rsp_id  output  IDW  index of the requester that produced rsp_data
rsp_err  output  1  illegal func flag (see Optional Feature)

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assert, active-low. Every register is cleared on the falling edge of rst_n, independent of clk.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, rr_ptr=0. req_ready is combinational, so it is 0 while in reset.
- Slot FSM:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on rsp_ready with no grant.
  - FULL -> FULL on rsp_ready with a grant (back-to-back).
- can_issue = EMPTY, or (FULL and rsp_ready). Full throughput is one op per cycle.
- Grant (combinational):
  - When can_issue, grant the first requester with req_valid set, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is one-hot on the granted requester. It is all-zero when can_issue=0 or no request is pending.
- req_ready never depends on req_valid of the same requester, beyond the grant selection itself.
- Handshake:
  - A request transfers when req_valid[i] and req_ready[i] are both high.
  - A requester holds its a/b/func stable while valid and not yet ready.
- On a grant to requester g:
  - The ALU is driven with requester g's operands.
  - rsp_data, rsp_id (=g) and rsp_err are loaded at the next edge.
  - rr_ptr <- (g+1) mod NREQ.
  - Latency: rsp_valid rises one cycle after acceptance.
- No grant: rr_ptr holds. rsp_data/rsp_id/rsp_err hold while FULL and not drained.
- rsp_valid, once high, stays high with stable data until rsp_ready is sampled high.
- Zero request with a pending slot: rsp_ready drains, and the slot goes EMPTY.
- Reset mid-operation drops the held result. A requester whose req_ready was high in the reset cycle is not considered accepted.
- Operand selection uses an indexed mux on the grant index. The ALU is purely combinational; the output register is the only pipeline stage.
- Arithmetic follows the ALU:
  - 32-bit two's complement; wrap on overflow, no carry/flag outputs.
  - Compares are signed, result 32'h1 or 32'h0.
  - MVHI = {b[15:0],16'h0}.

Optional Feature:
- Macro: ALU_SHARE_ARB_ILLEGAL_CHK_EN.
- Defined:
  - Illegal funcs are compare codes 5'b10100 and 5'b11100, and arithmetic codes other than 00000, 00001, 00100, 00101, 00110, 01011, 01100, 01101, 01110.
  - An illegal func loads rsp_data=0 and rsp_err=1. Grant/handshake/latency are unchanged.
- Not defined: rsp_err is tied 0 and rsp_data takes the raw ALU output for every code (X for illegal codes in simulation).

Decomposition:
- Shared package holds:
  - ALU func localparams (ADD, SUB, AND, OR, XOR, NAND, NOR, NXOR, MVHI and compare codes F..GTZ, 4-bit, plus the bit4 class select).
  - A function is_legal_func(5-bit) returning 1 for legal codes.
- One natural sub-module: rr_arbiter.
  - Parameterised NREQ.
  - Inputs: req vector, rr_ptr, enable (can_issue).
  - Outputs: one-hot grant and grant index.
- The top holds the slot register, rr_ptr and the ALU instance.

Test Plan:
- Reset: hold rst_n=0 mid-traffic, release -> rsp_valid=0, rr_ptr=0, req_ready=0 during reset.
- Single op, requester 0: a=7, b=-3, func=00001 (SUB), rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=10, rsp_id=0.
- Round-robin: both requesters valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id alternates; one result per cycle.
- Back-pressure: rsp_ready=0 for 3 cycles after first result (a=-5, b=0, func=10110 LTZ) -> rsp_data=1 held, req_ready all 0; first cycle rsp_ready=1 -> next grant issued in the same cycle.
- MVHI/wrap: a=32'h7FFFFFFF, b=1, func=00000 -> 32'h80000000; then b=32'h0000ABCD, func=01011 -> 32'hABCD0000.
- With ALU_SHARE_ARB_ILLEGAL_CHK_EN: func=00010 -> rsp_err=1, rsp_data=0; func=11100 -> rsp_err=1; func=11111 (GTZ, a=4) -> rsp_err=0, rsp_data=1.
